vis_framer: RTL
===============

Name: vis_framer

Overview:
- Receives the final visibility stream from the correlator accumulator: valid/first/last/data, with no backpressure.
- Captures each complete frame of NSUMS visibilities into a ping-pong (two-bank) buffer.
- Replays each frame on an AXI4-Stream master with full backpressure.
- Sits between the correlator and the readout/DMA path, absorbing downstream stalls so the no-backpressure producer never has to wait.

Parameters:
WIDTH, 36, visibility word width (matches accumulator output width)
NSUMS, 1024, visibilities per frame; frame length in words
ABITS, $clog2(NSUMS), local; bank address width

Ports:
clock_i  input  1  single system clock; all logic on rising edge
reset_i  input  1  synchronous, active-high reset
valid_i  input  1  input word valid; no backpressure, the word must be consumed
first_i  input  1  qualifies valid_i; first word of a frame
last_i  input  1  qualifies valid_i; final word of a frame
data_i  input  WIDTH  visibility word
m_tvalid_o  output  1  AXI4-Stream valid
m_tready_i  input  1  AXI4-Stream ready
m_tlast_o  output  1  high on word NSUMS-1 of each output frame
m_tdata_o  output  WIDTH  visibility word
overflow_o  output  1  sticky; a frame was dropped because both banks were busy
length_err_o  output  1  sticky; a frame arrived with length != NSUMS and was discarded

Behaviour:
- Reset values:
  - Outputs: m_tvalid_o=0, m_tlast_o=0, overflow_o=0, length_err_o=0. m_tdata_o is don't-care.
  - Internal: both banks marked empty, write FSM in W_IDLE, read FSM in R_IDLE.
  - Reset is asserted mid-frame on either side: all in-flight data discarded; m_tvalid_o=0 on the cycle after reset.
- Storage: two banks, each NSUMS x WIDTH, 1-cycle synchronous read. Per-bank state is EMPTY, FILLING, FULL or READING.
- Write FSM, states W_IDLE, W_FILL, W_DROP:
  - W_IDLE: on valid_i & first_i, select the write bank.
    - If the next bank in ping-pong order is EMPTY: mark it FILLING, write data_i at address 0, waddr=1, go to W_FILL.
    - Otherwise: set overflow_o, go to W_DROP.
  - W_IDLE: valid_i without first_i is ignored.
  - W_FILL: each valid_i writes data_i at waddr, then waddr increments.
  - W_FILL, valid_i & last_i:
    - If waddr==NSUMS-1: mark the bank FULL, toggle the ping-pong pointer, go to W_IDLE.
    - Otherwise: mark the bank EMPTY, set length_err_o, go to W_IDLE.
  - W_FILL, waddr reaches NSUMS-1 without last_i: the next valid word is a length error; the bank is freed and the FSM goes to W_DROP.
  - W_FILL, valid_i & first_i (resync): set length_err_o and restart the same bank at address 0 with this word.
  - W_DROP: discard words until valid_i & last_i, then go to W_IDLE.
  - W_DROP, valid_i & first_i: re-evaluate as in W_IDLE.
  - Single-word frame (first_i & last_i together): length error unless NSUMS==1.
- Read FSM, states R_IDLE, R_PREF, R_STREAM:
  - Frames are read in the order they were written.
  - R_IDLE: when the oldest bank is FULL, mark it READING, issue read of address 0, go to R_PREF.
  - R_PREF → R_STREAM: the returned word is loaded into the output register; m_tvalid_o=1.
  - First-word latency: m_tvalid_o rises 2 cycles after the bank becomes FULL.
  - R_STREAM: a 2-entry skid/prefetch keeps throughput at 1 word/cycle while m_tready_i=1.
  - m_tdata_o and m_tlast_o hold stable while m_tvalid_o & !m_tready_i.
  - m_tvalid_o never drops mid-frame.
  - Handshake on word NSUMS-1 (m_tlast_o=1): mark the bank EMPTY.
    - If the other bank is FULL on that same cycle: start its read immediately, giving back-to-back frames with at most 2 idle cycles.
    - Otherwise: go to R_IDLE.
- Simultaneous events:
  - Write-complete and read-release on the same cycle are both honoured.
  - A bank freed by the reader on cycle t is available to a first_i arriving on cycle t+1, not cycle t.
- Width: data is stored and output unmodified; no arithmetic on the data path.

Test Plan:
1. NSUMS=8, m_tready_i=1, one frame with data 1..8 -> m_tdata_o=1..8 on consecutive cycles; tlast on 8; first tvalid 2 cycles after the last input word; no error flags.
2. Same frame, with m_tready_i toggling 1,0,0,1 repeating -> output sequence 1..8 intact; data stable during stalls; m_tvalid_o continuous.
3. m_tready_i=0; three back-to-back frames A, B, C -> A and B buffered, C dropped, overflow_o=1. Then m_tready_i=1 -> outputs A then B (16 words, 2 tlasts) and nothing further.
4. Frame with last_i on word 6 -> length_err_o=1; no output. Next correct 8-word frame streams normally.
5. first_i reasserted at word 4 mid-frame, followed by 8 clean words -> length_err_o=1; output is only the 8 clean words.
6. Reset for 1 cycle while output word 3 is stalled -> next cycle m_tvalid_o=0 and all flags 0. A fresh frame then streams correctly.

Source files
------------

// File: rtl/vis_framer_if.sv
// vis_framer_if: AXI4-Stream style output bus of the visibility framer.
//   tvalid/tlast/tdata : driven by the master (framer)
//   tready             : driven by the slave (readout / DMA path)
interface vis_framer_if #(
  parameter int WIDTH = 36
) ();
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic [WIDTH-1:0] tdata;

  modport master (output tvalid, output tlast, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/vis_framer.sv
// vis_framer: captures complete NSUMS-word visibility frames from a producer
// that cannot be stalled into a two-bank ping-pong buffer and replays each
// frame on an AXI4-Stream master with full backpressure.
//   clock_i, reset_i         : clock, synchronous active-high reset
//   valid_i/first_i/last_i   : input word strobe and frame delimiters
//   data_i                   : input visibility word
//   m_axis (master)          : output stream tvalid/tready/tlast/tdata
//   overflow_o               : sticky, a frame was dropped (both banks busy)
//   length_err_o             : sticky, a frame of wrong length was discarded
//
// state    | meaning
// W_IDLE   | waiting for first_i
// W_FILL   | writing a frame into wbank_q
// W_DROP   | discarding the rest of a frame
// R_IDLE   | waiting for the oldest bank to become FULL
// R_PREF   | address 0 read issued, word in flight
// R_STREAM | streaming the bank out
module vis_framer #(
  parameter int WIDTH = 36,
  parameter int NSUMS = 1024
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic             first_i,
  input  logic             last_i,
  input  logic [WIDTH-1:0] data_i,
  vis_framer_if.master     m_axis,
  output logic             overflow_o,
  output logic             length_err_o
);
  localparam int ABITS = (NSUMS > 1) ? $clog2(NSUMS) : 1;
  // counters one bit wider so they can hold NSUMS ("all words done")
  localparam int CBITS = ABITS + 1;
  localparam logic [CBITS-1:0] LAST_ADDR = CBITS'(NSUMS - 1);
  localparam logic [CBITS-1:0] END_ADDR  = CBITS'(NSUMS);

  localparam logic [1:0] B_EMPTY = 2'd0, B_FILLING = 2'd1, B_FULL = 2'd2, B_READING = 2'd3;
  localparam logic [1:0] W_IDLE = 2'd0, W_FILL = 2'd1, W_DROP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_PREF = 2'd1, R_STREAM = 2'd2;

  logic [WIDTH-1:0] mem_q [2][NSUMS];
  logic [1:0][1:0]  bank_q, bank_d;

  logic [1:0]       wstate_q, wstate_d;
  logic             wbank_q, wbank_d, wptr_q, wptr_d;
  logic [CBITS-1:0] waddr_q, waddr_d;
  logic             overflow_q, overflow_d, length_err_q, length_err_d;
  logic             wr_en, wr_bank, wb_set, wb_idx, tgt, tgt_ok;
  logic [ABITS-1:0] wr_addr;
  logic [1:0]       wb_val;

  logic [1:0]       rstate_q, rstate_d;
  logic             rptr_q, rptr_d;
  logic [CBITS-1:0] raddr_q, raddr_d;
  logic             rd_en, rd_bank, rd_last, rd_rel, rd_start, pop, credit;
  logic [ABITS-1:0] rd_addr;
  logic [1:0]       occ;
  logic             rd_pend_q, rd_last_q;
  logic [WIDTH-1:0] rdata_q;

  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic             sk_valid_q, sk_valid_d, sk_last_q, sk_last_d;
  logic [WIDTH-1:0] out_data_q, out_data_d, sk_data_q, sk_data_d;

  // write side
  always_comb begin
    wstate_d = wstate_q;  wbank_d = wbank_q;  wptr_d = wptr_q;  waddr_d = waddr_q;
    overflow_d = overflow_q;  length_err_d = length_err_q;
    wr_en = 1'b0;  wr_bank = wbank_q;  wr_addr = '0;
    wb_set = 1'b0;  wb_idx = wbank_q;  wb_val = B_EMPTY;
    tgt = wptr_q;  tgt_ok = 1'b0;
    if (valid_i) begin
      if (first_i) begin
        // a first_i inside a frame restarts the same bank
        if (wstate_q == W_FILL) begin
          length_err_d = 1'b1;
          tgt = wbank_q;
          tgt_ok = 1'b1;
        end else begin
          tgt = wptr_q;
          tgt_ok = (bank_q[wptr_q] == B_EMPTY);
        end
        if (!tgt_ok) begin
          overflow_d = 1'b1;
          wstate_d = last_i ? W_IDLE : W_DROP;
        end else begin
          wr_en = 1'b1;  wr_bank = tgt;  wbank_d = tgt;
          waddr_d = CBITS'(1);
          wb_set = 1'b1;  wb_idx = tgt;
          if (last_i) begin
            wstate_d = W_IDLE;
            if (NSUMS == 1) begin
              wb_val = B_FULL;
              wptr_d = ~wptr_q;
            end else begin
              wb_val = B_EMPTY;
              length_err_d = 1'b1;
            end
          end else begin
            wb_val = B_FILLING;
            wstate_d = W_FILL;
          end
        end
      end else if (wstate_q == W_FILL) begin
        if (waddr_q == END_ADDR) begin
          // frame overran NSUMS words
          length_err_d = 1'b1;
          wb_set = 1'b1;  wb_val = B_EMPTY;
          wstate_d = last_i ? W_IDLE : W_DROP;
        end else begin
          wr_en = 1'b1;
          wr_addr = waddr_q[ABITS-1:0];
          waddr_d = waddr_q + CBITS'(1);
          if (last_i) begin
            wstate_d = W_IDLE;
            wb_set = 1'b1;
            if (waddr_q == LAST_ADDR) begin
              wb_val = B_FULL;
              wptr_d = ~wptr_q;
            end else begin
              wb_val = B_EMPTY;
              length_err_d = 1'b1;
            end
          end
        end
      end else if (wstate_q == W_DROP && last_i) begin
        wstate_d = W_IDLE;
      end
    end
  end

  // read side: output register + one skid entry + one read in flight;
  // a read is issued only when its word is guaranteed a slot
  always_comb begin
    rstate_d = rstate_q;  rptr_d = rptr_q;  raddr_d = raddr_q;
    rd_en = 1'b0;  rd_bank = rptr_q;  rd_addr = raddr_q[ABITS-1:0];
    rd_last = (raddr_q == LAST_ADDR);
    rd_rel = 1'b0;  rd_start = 1'b0;
    pop = out_valid_q & m_axis.tready;
    occ = {1'b0, out_valid_q} + {1'b0, sk_valid_q} + {1'b0, rd_pend_q};
    credit = (occ - {1'b0, pop}) < 2'd2;
    if (rstate_q == R_IDLE) begin
      if (bank_q[rptr_q] == B_FULL) begin
        rd_start = 1'b1;  rd_en = 1'b1;  rd_addr = '0;
        rd_last = (NSUMS == 1);
        raddr_d = CBITS'(1);
        rstate_d = R_PREF;
      end
    end else begin
      if (rstate_q == R_PREF) rstate_d = R_STREAM;
      if (raddr_q != END_ADDR && credit) begin
        rd_en = 1'b1;
        raddr_d = raddr_q + CBITS'(1);
      end
      if (pop && out_last_q) begin
        rd_rel = 1'b1;
        rptr_d = ~rptr_q;
        if (bank_q[~rptr_q] == B_FULL) begin
          rd_start = 1'b1;  rd_en = 1'b1;  rd_bank = ~rptr_q;  rd_addr = '0;
          rd_last = (NSUMS == 1);
          raddr_d = CBITS'(1);
          rstate_d = R_PREF;
        end else begin
          rstate_d = R_IDLE;
        end
      end
    end
  end

  // writer and reader never touch the same bank in one cycle
  always_comb begin
    bank_d = bank_q;
    if (wb_set)   bank_d[wb_idx]  = wb_val;
    if (rd_rel)   bank_d[rptr_q]  = B_EMPTY;
    if (rd_start) bank_d[rd_bank] = B_READING;
  end

  always_comb begin
    out_valid_d = out_valid_q;  out_data_d = out_data_q;  out_last_d = out_last_q;
    sk_valid_d = sk_valid_q;    sk_data_d = sk_data_q;    sk_last_d = sk_last_q;
    if (!out_valid_q || pop) begin
      if (sk_valid_q) begin
        out_valid_d = 1'b1;  out_data_d = sk_data_q;  out_last_d = sk_last_q;
        sk_valid_d = rd_pend_q;  sk_data_d = rdata_q;  sk_last_d = rd_last_q;
      end else begin
        out_valid_d = rd_pend_q;  out_data_d = rdata_q;  out_last_d = rd_pend_q & rd_last_q;
      end
    end else if (rd_pend_q) begin
      sk_valid_d = 1'b1;  sk_data_d = rdata_q;  sk_last_d = rd_last_q;
    end
  end

  always_ff @(posedge clock_i) begin
    if (wr_en) mem_q[wr_bank][wr_addr] <= data_i;
    if (rd_en) rdata_q <= mem_q[rd_bank][rd_addr];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      bank_q <= '0;
      wstate_q <= W_IDLE;  wbank_q <= 1'b0;  wptr_q <= 1'b0;  waddr_q <= '0;
      overflow_q <= 1'b0;  length_err_q <= 1'b0;
      rstate_q <= R_IDLE;  rptr_q <= 1'b0;  raddr_q <= '0;
      rd_pend_q <= 1'b0;  rd_last_q <= 1'b0;
      out_valid_q <= 1'b0;  out_data_q <= '0;  out_last_q <= 1'b0;
      sk_valid_q <= 1'b0;   sk_data_q <= '0;   sk_last_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
      wstate_q <= wstate_d;  wbank_q <= wbank_d;  wptr_q <= wptr_d;  waddr_q <= waddr_d;
      overflow_q <= overflow_d;  length_err_q <= length_err_d;
      rstate_q <= rstate_d;  rptr_q <= rptr_d;  raddr_q <= raddr_d;
      rd_pend_q <= rd_en;
      if (rd_en) rd_last_q <= rd_last;
      out_valid_q <= out_valid_d;  out_data_q <= out_data_d;  out_last_q <= out_last_d;
      sk_valid_q <= sk_valid_d;    sk_data_q <= sk_data_d;    sk_last_q <= sk_last_d;
    end
  end

  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tlast  = out_last_q;
  assign m_axis.tdata  = out_data_q;
  assign overflow_o    = overflow_q;
  assign length_err_o  = length_err_q;
endmodule
